fft_frame_ctrl: RTL and testbench

- Sequences the FFT datapath. Decimates the incoming audio sample strobe stream and writes N samples into the FFT input buffer.
- Once the frame is complete, pulses the FFT start, waits for FFT completion and raises done to the MCU. It holds the frame until the MCU finishes its SPI readout (cs low-then-high), then re-arms.
- Sits between the I2S sample-valid detector and the fft core. Runs entirely in the 48 MHz HSOSC domain.

---
 rtl/fft_pkg.sv | 14 +
 rtl/cs_sync.sv | 38 +++
 rtl/fft_frame_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame sequencing blocks.
package fft_pkg;

  localparam int unsigned FFT_N    = 256;
  localparam int unsigned SAMPLE_W = 32;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    COMPUTE   = 2'd1,
    WAIT_READ = 2'd2,
    READOUT   = 2'd3
  } fft_state_e;

endpackage

// File: rtl/cs_sync.sv
// Two-flop synchronizer for the MCU chip select, plus an edge-history flop
// that turns the synchronized level into one-cycle rise/fall pulses.
module cs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_in,
  output logic cs_rise,
  output logic cs_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  // Next-state: shift the raw level through the synchronizer chain.
  always_comb begin
    meta_d = cs_in;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Chain resets to the idle (deselected, high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign cs_rise =  sync_q & ~hist_q;
  assign cs_fall = ~sync_q &  hist_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FFT datapath: decimates the sample strobe stream
// into an N-entry buffer, starts the transform, waits for completion, then
// holds the result until the MCU finishes its chip-select readout.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N       = FFT_N,
  parameter int unsigned DECIM   = 1,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  fft_done,
  input  logic                  cs,
  output logic                  wr_en,
  output logic [$clog2(N)-1:0]  wr_addr,
  output logic [SAMPLE_W-1:0]   wr_data,
  output logic                  fft_start,
  output logic                  done,
  output logic                  timeout_err,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fft_state_e          state_q, state_d;
  logic [AW-1:0]       fill_ptr_q, fill_ptr_d;
  logic [DW-1:0]       decim_q, decim_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic                fft_start_q, fft_start_d;
  logic                done_q, done_d;
  logic                timeout_err_q, timeout_err_d;
  logic [7:0]          drop_q, drop_d;

  logic cs_rise;
  logic cs_fall;
  logic frame_full;
  logic accept;

  cs_sync u_cs_sync (
    .clk     (clk),
    .rst_n   (reset),
    .cs_in   (cs),
    .cs_rise (cs_rise),
    .cs_fall (cs_fall)
  );

  // The cycle after the last buffer write is spent issuing fft_start while
  // still nominally in FILL; a strobe landing there is counted as dropped so
  // wr_en can never coincide with COMPUTE.
  assign frame_full = wr_en_q && (wr_addr_q == AW'(N - 1));
  assign accept     = sample_valid && (state_q == FILL) && !frame_full;

  // Next-state and output-register logic for the frame sequencer.
  always_comb begin
    state_d       = state_q;
    fill_ptr_d    = fill_ptr_q;
    decim_d       = decim_q;
    tmo_d         = tmo_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    fft_start_d   = 1'b0;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    drop_d        = drop_q;

    if (sample_valid && !accept && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      FILL: begin
        if (frame_full) begin
          fft_start_d = 1'b1;
          state_d     = COMPUTE;
          fill_ptr_d  = '0;
          tmo_d       = '0;
        end else if (sample_valid) begin
          if (decim_q == '0) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = fill_ptr_q;
            wr_data_d  = sample_in;
            fill_ptr_d = fill_ptr_q + AW'(1);
          end
          decim_d = (decim_q == DW'(DECIM - 1)) ? '0 : decim_q + DW'(1);
        end
      end
      COMPUTE: begin
        if (fft_done) begin
          done_d  = 1'b1;
          state_d = WAIT_READ;
          tmo_d   = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = FILL;
          fill_ptr_d    = '0;
          tmo_d         = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_READ: begin
        if (cs_fall) begin
          state_d = READOUT;
        end
      end
      READOUT: begin
        if (cs_rise) begin
          done_d     = 1'b0;
          state_d    = FILL;
          fill_ptr_d = '0;
          decim_d    = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and registered outputs; async reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FILL;
      fill_ptr_q    <= '0;
      decim_q       <= '0;
      tmo_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      fft_start_q   <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      fill_ptr_q    <= fill_ptr_d;
      decim_q       <= decim_d;
      tmo_q         <= tmo_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      fft_start_q   <= fft_start_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      drop_q        <= drop_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign fft_start   = fft_start_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: two instances (DECIM=1 and DECIM=4, N=16,
// TIMEOUT=32) driven with random samples and checked against a frame model.
module tb_fft_frame_ctrl;

  localparam int unsigned N   = 16;
  localparam int unsigned TMO = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, sv1, fd1, cs1;
  logic [31:0] sin1;
  logic        wr_en1, fft_start1, done1, timeout_err1;
  logic [3:0]  wr_addr1;
  logic [31:0] wr_data1;
  logic [7:0]  drop_cnt1;

  logic        rst4, sv4, fd4, cs4;
  logic [31:0] sin4;
  logic        wr_en4, fft_start4, done4, timeout_err4;
  logic [3:0]  wr_addr4;
  logic [31:0] wr_data4;
  logic [7:0]  drop_cnt4;

  fft_frame_ctrl #(.N(N), .DECIM(1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .reset(rst1), .sample_valid(sv1), .sample_in(sin1),
    .fft_done(fd1), .cs(cs1), .wr_en(wr_en1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .fft_start(fft_start1), .done(done1),
    .timeout_err(timeout_err1), .drop_cnt(drop_cnt1)
  );

  fft_frame_ctrl #(.N(N), .DECIM(4), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .reset(rst4), .sample_valid(sv4), .sample_in(sin4),
    .fft_done(fd4), .cs(cs4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .fft_start(fft_start4), .done(done4),
    .timeout_err(timeout_err4), .drop_cnt(drop_cnt4)
  );

  int total = 0;
  int bad   = 0;

  // Frame model per instance (0 = DECIM 1, 1 = DECIM 4).
  int m_ptr[2];
  int m_dec[2];
  int m_drop[2];
  bit m_full[2];
  int dec_of[2] = '{1, 4};

  // Event monitors, sampled on the falling edge.
  int start_cnt1 = 0;
  int start_cnt4 = 0;
  int wr_cnt4    = 0;
  always @(negedge clk) begin
    if (fft_start1) start_cnt1++;
    if (fft_start4) start_cnt4++;
    if (wr_en4)     wr_cnt4++;
  end

  function automatic logic [31:0] rand_sample();
    logic [31:0] r;
    r = $urandom();
    return {r[23:0], 8'h00};
  endfunction

  // Every DECIM-th accepted strobe lands at the next buffer slot; once N
  // slots are filled the frame is closed and further strobes are drops.
  function automatic bit model_strobe(input int w, output int addr);
    bit wr;
    addr = 0;
    wr   = 1'b0;
    if (m_full[w]) begin
      if (m_drop[w] < 255) m_drop[w]++;
    end else begin
      wr = (m_dec[w] == 0);
      if (wr) begin
        addr = m_ptr[w];
        m_ptr[w]++;
        if (m_ptr[w] == int'(N)) begin
          m_ptr[w]  = 0;
          m_full[w] = 1'b1;
        end
      end
      m_dec[w] = (m_dec[w] + 1) % dec_of[w];
    end
    return wr;
  endfunction

  function automatic void model_rearm(input int w, input bit clr_dec);
    m_full[w] = 1'b0;
    m_ptr[w]  = 0;
    if (clr_dec) m_dec[w] = 0;
  endfunction

  function automatic void model_reset(input int w);
    m_full[w] = 1'b0;
    m_ptr[w]  = 0;
    m_dec[w]  = 0;
    m_drop[w] = 0;
  endfunction

  // One strobe after a random idle gap; returns the outputs one cycle later.
  task automatic strobe(input int w, input logic [31:0] d, output logic we,
                        output logic [3:0] a, output logic [31:0] wd);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    if (w == 0) begin sv1 = 1'b1; sin1 = d; end
    else        begin sv4 = 1'b1; sin4 = d; end
    @(negedge clk);
    sv1 = 1'b0;
    sv4 = 1'b0;
    we = (w == 0) ? wr_en1   : wr_en4;
    a  = (w == 0) ? wr_addr1 : wr_addr4;
    wd = (w == 0) ? wr_data1 : wr_data4;
  endtask

  task automatic test_reset();
    rst1 = 1'b0; rst4 = 1'b0;
    sv1 = 1'b0; sv4 = 1'b0; fd1 = 1'b0; fd4 = 1'b0;
    cs1 = 1'b1; cs4 = 1'b1; sin1 = '0; sin4 = '0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    total++; if (wr_en1 !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %0b want 0", wr_en1); end
    total++; if (wr_addr1 !== 4'd0) begin bad++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr1); end
    total++; if (wr_data1 !== 32'd0) begin bad++; $display("FAIL rst_wr_data: got %0h want 0", wr_data1); end
    total++; if (fft_start1 !== 1'b0) begin bad++; $display("FAIL rst_fft_start: got %0b want 0", fft_start1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", done1); end
    total++; if (timeout_err1 !== 1'b0) begin bad++; $display("FAIL rst_timeout_err: got %0b want 0", timeout_err1); end
    total++; if (drop_cnt1 !== 8'd0) begin bad++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt1); end
    total++; if ({wr_en4, done4, drop_cnt4} !== 10'd0) begin bad++; $display("FAIL rst_dut4: got %0h want 0", {wr_en4, done4, drop_cnt4}); end
    rst1 = 1'b1;
    rst4 = 1'b1;
  endtask

  task automatic test_fill_decim1();
    logic we; logic [3:0] a; logic [31:0] wd, d; bit exp; int ea, s0;
    s0 = start_cnt1;
    for (int k = 0; k < int'(N); k++) begin
      d   = rand_sample();
      exp = model_strobe(0, ea);
      strobe(0, d, we, a, wd);
      total++; if (we !== exp) begin bad++; $display("FAIL fill1_wr_en[%0d]: got %0b want %0b", k, we, exp); end
      if (exp) begin
        total++; if (a !== 4'(ea)) begin bad++; $display("FAIL fill1_addr[%0d]: got %0d want %0d", k, a, ea); end
        total++; if (wd !== d) begin bad++; $display("FAIL fill1_data[%0d]: got %0h want %0h", k, wd, d); end
      end
    end
    @(negedge clk);
    total++; if (fft_start1 !== 1'b1) begin bad++; $display("FAIL fill1_start: got %0b want 1", fft_start1); end
    @(negedge clk);
    #1;
    total++; if (fft_start1 !== 1'b0) begin bad++; $display("FAIL fill1_start_pulse: got %0b want 0", fft_start1); end
    total++; if (start_cnt1 - s0 !== 1) begin bad++; $display("FAIL fill1_start_count: got %0d want 1", start_cnt1 - s0); end
  endtask

  task automatic test_done_readout();
    logic we; logic [3:0] a; logic [31:0] wd, d; bit exp; int ea;
    repeat (3) @(negedge clk);
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL dr_done_early: got %0b want 0", done1); end
    fd1 = 1'b1;
    @(negedge clk);
    fd1 = 1'b0;
    total++; if (done1 !== 1'b1) begin bad++; $display("FAIL dr_done_set: got %0b want 1", done1); end
    for (int k = 0; k < 5; k++) begin
      exp = model_strobe(0, ea);
      strobe(0, rand_sample(), we, a, wd);
      total++; if (we !== exp) begin bad++; $display("FAIL dr_drop_wr_en[%0d]: got %0b want %0b", k, we, exp); end
    end
    total++; if (drop_cnt1 !== 8'(m_drop[0])) begin bad++; $display("FAIL dr_drop_cnt: got %0d want %0d", drop_cnt1, m_drop[0]); end
    @(negedge clk);
    cs1 = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (done1 !== 1'b1) begin bad++; $display("FAIL dr_done_cs_low: got %0b want 1", done1); end
    cs1 = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (done1 !== 1'b1) begin bad++; $display("FAIL dr_done_sync_hold: got %0b want 1", done1); end
    @(negedge clk);
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL dr_done_clear: got %0b want 0", done1); end
    model_rearm(0, 1'b1);
    d   = rand_sample();
    exp = model_strobe(0, ea);
    strobe(0, d, we, a, wd);
    total++; if ({we, a, wd} !== {exp, 4'(ea), d}) begin bad++; $display("FAIL dr_rearm_write: got %0b/%0d/%0h want %0b/%0d/%0h", we, a, wd, exp, ea, d); end
  endtask

  task automatic test_timeout();
    logic we; logic [3:0] a; logic [31:0] wd, d; bit exp; int ea, s0;
    s0 = start_cnt1;
    while (!m_full[0]) begin
      exp = model_strobe(0, ea);
      strobe(0, rand_sample(), we, a, wd);
    end
    @(negedge clk);
    total++; if (fft_start1 !== 1'b1) begin bad++; $display("FAIL tmo_start: got %0b want 1", fft_start1); end
    repeat (TMO - 1) @(negedge clk);
    total++; if (timeout_err1 !== 1'b0) begin bad++; $display("FAIL tmo_early: got %0b want 0", timeout_err1); end
    @(negedge clk);
    total++; if (timeout_err1 !== 1'b1) begin bad++; $display("FAIL tmo_set: got %0b want 1", timeout_err1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL tmo_done: got %0b want 0", done1); end
    #1;
    total++; if (start_cnt1 - s0 !== 1) begin bad++; $display("FAIL tmo_start_count: got %0d want 1", start_cnt1 - s0); end
    model_rearm(0, 1'b0);
    d   = rand_sample();
    exp = model_strobe(0, ea);
    strobe(0, d, we, a, wd);
    total++; if ({we, a, wd} !== {exp, 4'(ea), d}) begin bad++; $display("FAIL tmo_refill: got %0b/%0d/%0h want %0b/%0d/%0h", we, a, wd, exp, ea, d); end
    total++; if (timeout_err1 !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %0b want 1", timeout_err1); end
  endtask

  task automatic test_decim4();
    logic we; logic [3:0] a; logic [31:0] wd, d; bit exp; int ea, s0, nw;
    s0 = start_cnt4;
    nw = 0;
    for (int k = 0; k < 64; k++) begin
      d   = rand_sample();
      exp = model_strobe(1, ea);
      strobe(1, d, we, a, wd);
      if (we === 1'b1) nw++;
      total++; if (we !== exp) begin bad++; $display("FAIL d4_wr_en[%0d]: got %0b want %0b", k, we, exp); end
      if (exp) begin
        total++; if ({a, wd} !== {4'(ea), d}) begin bad++; $display("FAIL d4_write[%0d]: got %0d/%0h want %0d/%0h", k, a, wd, ea, d); end
      end
    end
    #1;
    total++; if (nw !== 16) begin bad++; $display("FAIL d4_write_count: got %0d want 16", nw); end
    total++; if (start_cnt4 - s0 !== 1) begin bad++; $display("FAIL d4_start_count: got %0d want 1", start_cnt4 - s0); end
    total++; if (drop_cnt4 !== 8'(m_drop[1])) begin bad++; $display("FAIL d4_drop_cnt: got %0d want %0d", drop_cnt4, m_drop[1]); end
  endtask

  task automatic test_saturate();
    int ea, w0;
    bit exp;
    @(negedge clk);
    fd4 = 1'b1;
    @(negedge clk);
    fd4 = 1'b0;
    total++; if (done4 !== 1'b1) begin bad++; $display("FAIL sat_done: got %0b want 1", done4); end
    w0 = wr_cnt4;
    sv4 = 1'b1;
    sin4 = rand_sample();
    repeat (300) begin
      @(negedge clk);
      exp = model_strobe(1, ea);
    end
    sv4 = 1'b0;
    @(negedge clk);
    #1;
    total++; if (drop_cnt4 !== 8'd255) begin bad++; $display("FAIL sat_drop_cnt: got %0d want 255", drop_cnt4); end
    total++; if (wr_cnt4 - w0 !== 0) begin bad++; $display("FAIL sat_no_write: got %0d want 0", wr_cnt4 - w0); end
    total++; if (done4 !== 1'b1) begin bad++; $display("FAIL sat_done_hold: got %0b want 1", done4); end
  endtask

  task automatic test_reset_fill1();
    logic we; logic [3:0] a; logic [31:0] wd, d; bit exp; int ea, s0;
    while (m_ptr[0] != 7) begin
      exp = model_strobe(0, ea);
      strobe(0, rand_sample(), we, a, wd);
    end
    exp = model_strobe(0, ea);
    strobe(0, rand_sample(), we, a, wd);
    total++; if ({we, a} !== {1'b1, 4'd7}) begin bad++; $display("FAIL rf_addr7: got %0b/%0d want 1/7", we, a); end
    #2 rst1 = 1'b0;
    #1;
    total++; if ({wr_en1, wr_addr1, wr_data1} !== 37'd0) begin bad++; $display("FAIL rf_wr_regs: got %0b/%0d/%0h want 0/0/0", wr_en1, wr_addr1, wr_data1); end
    total++; if (timeout_err1 !== 1'b0) begin bad++; $display("FAIL rf_timeout_err: got %0b want 0", timeout_err1); end
    total++; if (drop_cnt1 !== 8'd0) begin bad++; $display("FAIL rf_drop_cnt: got %0d want 0", drop_cnt1); end
    model_reset(0);
    s0 = start_cnt1;
    @(negedge clk);
    rst1 = 1'b1;
    d   = rand_sample();
    exp = model_strobe(0, ea);
    strobe(0, d, we, a, wd);
    total++; if ({we, a, wd} !== {exp, 4'(ea), d}) begin bad++; $display("FAIL rf_after_release: got %0b/%0d/%0h want %0b/%0d/%0h", we, a, wd, exp, ea, d); end
    #1;
    total++; if (start_cnt1 - s0 !== 0) begin bad++; $display("FAIL rf_no_start: got %0d want 0", start_cnt1 - s0); end
  endtask

  task automatic test_reset_readout4();
    logic we; logic [3:0] a; logic [31:0] wd, d; bit exp; int ea, s0;
    @(negedge clk);
    cs4 = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (done4 !== 1'b1) begin bad++; $display("FAIL rr_done_readout: got %0b want 1", done4); end
    #2 rst4 = 1'b0;
    #1;
    total++; if ({done4, fft_start4, wr_en4} !== 3'b000) begin bad++; $display("FAIL rr_ctrl_regs: got %0b want 000", {done4, fft_start4, wr_en4}); end
    total++; if (drop_cnt4 !== 8'd0) begin bad++; $display("FAIL rr_drop_cnt: got %0d want 0", drop_cnt4); end
    model_reset(1);
    cs4 = 1'b1;
    repeat (2) @(negedge clk);
    s0 = start_cnt4;
    rst4 = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL rr_done_release: got %0b want 0", done4); end
    total++; if (start_cnt4 - s0 !== 0) begin bad++; $display("FAIL rr_no_start: got %0d want 0", start_cnt4 - s0); end
    d   = rand_sample();
    exp = model_strobe(1, ea);
    strobe(1, d, we, a, wd);
    total++; if ({we, a, wd} !== {exp, 4'(ea), d}) begin bad++; $display("FAIL rr_after_release: got %0b/%0d/%0h want %0b/%0d/%0h", we, a, wd, exp, ea, d); end
  endtask

  initial begin
    test_reset();
    test_fill_decim1();
    test_done_readout();
    test_timeout();
    test_decim4();
    test_saturate();
    test_reset_fill1();
    test_reset_readout4();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
